alu_dispatcher: RTL

Upstream command stage for the ALU. It buffers operation requests in a small FIFO and issues them to the ALU one at a time through start_alu, op, A and B. It waits for completion, using a fixed latency for single-cycle ops and valid_alu for multi-cycle ops. It returns each result with its tag on a valid/ready response port, with error and timeout flags.

---
 rtl/alu_dispatcher_if.sv | 55 +++++
 rtl/alu_dispatcher.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_dispatcher_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_dispatcher_if
// Description : Bundles the command, ALU-issue and response signals of the
//               ALU dispatcher. "slave" is the dispatcher's view, "master"
//               is the view of the surrounding requester/ALU environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_dispatcher_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    // Command side
    logic             cmd_valid;
    logic             cmd_ready;
    logic [4:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [TAG_W-1:0] cmd_tag;

    // ALU side
    logic             start_alu;
    logic [4:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] alu_result;
    logic             valid_alu;
    logic             busy_alu;
    logic             error_alu;

    // Response side
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_error;
    logic             rsp_timeout;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag,
        input  alu_result, valid_alu, busy_alu, error_alu,
        input  rsp_ready,
        output cmd_ready, start_alu, op, A, B,
        output rsp_valid, rsp_data, rsp_tag, rsp_error, rsp_timeout
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag,
        output alu_result, valid_alu, busy_alu, error_alu,
        output rsp_ready,
        input  cmd_ready, start_alu, op, A, B,
        input  rsp_valid, rsp_data, rsp_tag, rsp_error, rsp_timeout
    );
endinterface
`default_nettype wire

// File: rtl/alu_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : alu_dispatcher
// Description : Buffers ALU commands in a small FIFO, issues them one at a
//               time, waits for a fixed latency or for valid_alu depending on
//               the opcode class, and returns tagged results on a
//               valid/ready response port with error and timeout flags.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_dispatcher #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4,
    parameter int TAG_W     = 4,
    parameter int FIXED_LAT = 3,
    parameter int TIMEOUT   = 1023
) (
    input  logic                   clk,
    input  logic                   rst,
    alu_dispatcher_if.slave        bus,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_MAX = (TIMEOUT > FIXED_LAT) ? TIMEOUT : FIXED_LAT;
    localparam int CYC_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ISSUE      = 3'd1,
        WAIT_FIX   = 3'd2,
        WAIT_VALID = 3'd3,
        RESP       = 3'd4
    } state_t;

    // Opcodes 0x08-0x0B and 0x0E complete via valid_alu; 0x10-0x1F are illegal
    function automatic logic is_valid_wait(input logic [4:0] opc);
        logic res;
        res = 1'b0;
        case (opc)
            5'h08, 5'h09, 5'h0A, 5'h0B, 5'h0E: res = 1'b1;
            default:                           res = 1'b0;
        endcase
        return res;
    endfunction

    // FIFO storage and bookkeeping
    logic [4:0]       r_mem_op  [DEPTH];
    logic [WIDTH-1:0] r_mem_a   [DEPTH];
    logic [WIDTH-1:0] r_mem_b   [DEPTH];
    logic [TAG_W-1:0] r_mem_tag [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [PTR_W:0]   w_count_next;
    logic             r_cmd_ready;
    logic             w_push;
    logic             w_pop;

    // Issued command and response registers
    state_t           r_state;
    state_t           w_next_state;
    logic [4:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [TAG_W-1:0] r_tag;
    logic [CYC_W-1:0] r_cyc;
    logic [WIDTH-1:0] r_rsp_data;
    logic [TAG_W-1:0] r_rsp_tag;
    logic             r_rsp_error;
    logic             r_rsp_timeout;
    logic             w_start_alu;
    logic             w_rsp_valid;

    logic [4:0]       w_head_op;
    logic             w_head_illegal;
    logic             w_fix_done;
    logic             w_timeout_hit;

    assign w_push         = bus.cmd_valid && r_cmd_ready;
    assign w_head_op      = r_mem_op[r_rd_ptr];
    assign w_head_illegal = w_head_op[4];
    assign w_fix_done     = (r_cyc == CYC_W'(FIXED_LAT - 1));
    assign w_timeout_hit  = (r_cyc == CYC_W'(TIMEOUT - 1));

    // Occupancy after this cycle's push/pop
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + (PTR_W + 1)'(1);
            2'b01:   w_count_next = r_count - (PTR_W + 1)'(1);
            default: w_count_next = r_count;
        endcase
    end

    // FIFO payload write; storage needs no reset since count gates reads
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_op[r_wr_ptr]  <= bus.cmd_op;
            r_mem_a[r_wr_ptr]   <= bus.cmd_a;
            r_mem_b[r_wr_ptr]   <= bus.cmd_b;
            r_mem_tag[r_wr_ptr] <= bus.cmd_tag;
        end
    end

    // FIFO pointers, count and registered ready (a pop frees space next cycle)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_cmd_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count     <= w_count_next;
            r_cmd_ready <= (w_count_next < (PTR_W + 1)'(DEPTH));
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, pop decision and state-decoded strobes
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_start_alu  = 1'b0;
        w_rsp_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                if ((r_count != '0) && !bus.busy_alu) begin
                    w_pop        = 1'b1;
                    w_next_state = w_head_illegal ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                w_start_alu  = 1'b1;
                w_next_state = is_valid_wait(r_op) ? WAIT_VALID : WAIT_FIX;
            end
            WAIT_FIX: begin
                if (w_fix_done) begin
                    w_next_state = RESP;
                end
            end
            WAIT_VALID: begin
                if (bus.valid_alu || w_timeout_hit) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Command capture, wait counter and response latching
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op          <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_tag         <= '0;
            r_cyc         <= '0;
            r_rsp_data    <= '0;
            r_rsp_tag     <= '0;
            r_rsp_error   <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            if (w_pop) begin
                r_op  <= w_head_op;
                r_a   <= r_mem_a[r_rd_ptr];
                r_b   <= r_mem_b[r_rd_ptr];
                r_tag <= r_mem_tag[r_rd_ptr];
            end
            case (r_state)
                IDLE: begin
                    // Illegal opcodes bypass the ALU and answer immediately
                    if (w_pop && w_head_illegal) begin
                        r_rsp_data    <= '0;
                        r_rsp_tag     <= r_mem_tag[r_rd_ptr];
                        r_rsp_error   <= 1'b1;
                        r_rsp_timeout <= 1'b0;
                    end
                end
                ISSUE: begin
                    r_cyc <= '0;
                end
                WAIT_FIX: begin
                    r_cyc <= r_cyc + CYC_W'(1);
                    if (w_fix_done) begin
                        r_rsp_data    <= bus.alu_result;
                        r_rsp_tag     <= r_tag;
                        r_rsp_error   <= 1'b0;
                        r_rsp_timeout <= 1'b0;
                    end
                end
                WAIT_VALID: begin
                    r_cyc <= r_cyc + CYC_W'(1);
                    if (bus.valid_alu) begin
                        r_rsp_data    <= bus.alu_result;
                        r_rsp_tag     <= r_tag;
                        r_rsp_error   <= bus.error_alu;
                        r_rsp_timeout <= 1'b0;
                    end else if (w_timeout_hit) begin
                        r_rsp_data    <= '0;
                        r_rsp_tag     <= r_tag;
                        r_rsp_error   <= 1'b0;
                        r_rsp_timeout <= 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_data    <= '0;
                        r_rsp_tag     <= '0;
                        r_rsp_error   <= 1'b0;
                        r_rsp_timeout <= 1'b0;
                    end
                end
                default: begin
                    r_cyc <= '0;
                end
            endcase
        end
    end

    assign bus.cmd_ready   = r_cmd_ready;
    assign bus.start_alu   = w_start_alu;
    assign bus.op          = r_op;
    assign bus.A           = r_a;
    assign bus.B           = r_b;
    assign bus.rsp_valid   = w_rsp_valid;
    assign bus.rsp_data    = r_rsp_data;
    assign bus.rsp_tag     = r_rsp_tag;
    assign bus.rsp_error   = r_rsp_error;
    assign bus.rsp_timeout = r_rsp_timeout;
    assign fifo_count      = r_count;

endmodule
`default_nettype wire
